// File: rtl/rc6_key_sched_pkg.sv
// RC6-32/20/16 shared constants, word type and key-schedule state encoding.
// Imported by the key scheduler, its interface and the cipher core.
package rc6_pkg;

    localparam int W         = 32;
    localparam int R         = 20;
    localparam int T         = 2 * R + 4;
    localparam int KW        = 4;
    localparam int AW        = 5;
    localparam int MIX_ITERS = 3 * T;
    localparam int KWORDS    = R + 2;

    localparam logic [W-1:0] P32 = 32'hB7E15163;
    localparam logic [W-1:0] Q32 = 32'h9E3779B9;

    typedef logic [W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MIX,
        OUT,
        DONE
    } ks_state_t;

endpackage

// File: rtl/rc6_key_sched_if.sv
// Request/status and key-store write bundle of the RC6 key scheduler.
// master: requester (drives start/key_in); slave: the key scheduler.
interface rc6_key_sched_if;
    import rc6_pkg::*;

    logic              start;
    logic [KW*W-1:0]   key_in;
    logic              busy;
    logic              done;
    logic              kwr_en;
    logic [AW-1:0]     kwr_addr;
    logic [2*W-1:0]    kwr_data;

    modport master (
        output start, key_in,
        input  busy, done, kwr_en, kwr_addr, kwr_data
    );

    modport slave (
        input  start, key_in,
        output busy, done, kwr_en, kwr_addr, kwr_data
    );

endinterface

// File: rtl/rc6_key_sched_rotl32.sv
// Combinational 32-bit left rotate by a 5-bit amount.
// Ports: data_i (word), amt_i (rotate count), data_o (rotated word).
module rc6_rotl32
    import rc6_pkg::*;
(
    input  word_t      data_i,
    input  logic [4:0] amt_i,
    output word_t      data_o
);

    // A right shift by 32 yields zero, so amt_i == 0 passes data through.
    assign data_o = (data_i << amt_i) | (data_i >> (6'd32 - {1'b0, amt_i}));

endmodule

// File: rtl/rc6_key_sched.sv
// RC6-32/20/16 key expansion: builds S[0..43] and writes 22 packed words.
// Ports: clk, reset (sync, active-low), bus (slave: start/key_in in,
// busy/done/kwr_en/kwr_addr/kwr_data out).
module rc6_key_sched
    import rc6_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    rc6_key_sched_if.slave bus
);

    ks_state_t      state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           wen_q, wen_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [2*W-1:0] wdata_q, wdata_d;

    logic           ld_key;
    logic           init_we;
    logic           mix_we;

    word_t          s_q [T];
    word_t          l_q [KW];
    word_t          acc_q;
    word_t          a_q, b_q;
    logic [5:0]     i_q;
    logic [1:0]     j_q;

    word_t          sum_a, a_n;
    word_t          ab, sum_b, b_n;

    // One mixing step: A' = ROTL(S[i]+A+B, 3), B' = ROTL(L[j]+A'+B, A'+B).
    assign sum_a = s_q[i_q] + a_q + b_q;
    assign ab    = a_n + b_q;
    assign sum_b = l_q[j_q] + ab;

    rc6_rotl32 u_rot_a (
        .data_i (sum_a),
        .amt_i  (5'd3),
        .data_o (a_n)
    );

    rc6_rotl32 u_rot_b (
        .data_i (sum_b),
        .amt_i  (ab[4:0]),
        .data_o (b_n)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        ld_key  = 1'b0;
        init_we = 1'b0;
        mix_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ld_key  = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                init_we = 1'b1;
                if (cnt_q == 8'(T - 1)) begin
                    cnt_d   = '0;
                    state_d = MIX;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            MIX: begin
                mix_we = 1'b1;
                if (cnt_q == 8'(MIX_ITERS - 1)) begin
                    cnt_d   = '0;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            OUT: begin
                wen_d   = 1'b1;
                waddr_d = cnt_q[AW-1:0];
                wdata_d = {s_q[{cnt_q[4:0], 1'b0}],
                           s_q[{cnt_q[4:0], 1'b1}]};
                if (cnt_q == 8'(KWORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Working storage is never cleared; a reset edge only freezes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (ld_key) begin
                for (int k = 0; k < KW; k++) begin
                    l_q[k] <= bus.key_in[W*k +: W];
                end
                acc_q <= P32;
            end
            if (init_we) begin
                s_q[cnt_q[5:0]] <= acc_q;
                acc_q           <= acc_q + Q32;
                a_q             <= '0;
                b_q             <= '0;
                i_q             <= '0;
                j_q             <= '0;
            end
            if (mix_we) begin
                s_q[i_q] <= a_n;
                l_q[j_q] <= b_n;
                a_q      <= a_n;
                b_q      <= b_n;
                i_q      <= (i_q == 6'(T - 1)) ? 6'd0 : i_q + 6'd1;
                j_q      <= j_q + 2'd1;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.kwr_en   = wen_q;
    assign bus.kwr_addr = waddr_q;
    assign bus.kwr_data = wdata_q;

endmodule

// File: tb/tb_rc6_key_sched.sv
// Self-checking bench for rc6_key_sched: scoreboarded key-store writes,
// reference key schedule and RC6 cipher model for known-answer vectors.
module tb_rc6_key_sched;
    import rc6_pkg::*;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    rc6_key_sched_if bus();

    rc6_key_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    errors = 0;
    int    checks = 0;
    int    wr_cnt = 0;
    int    acc_cyc = 0;
    wr_t   sb[$];
    word_t ms[44];
    word_t sk[44];
    logic [63:0] ks[22];
    vec_t  vecs[2];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Key-store model plus scoreboard of expected writes.
    always @(negedge clk) begin
        wr_t e;
        if (bus.kwr_en === 1'b1) begin
            wr_cnt++;
            if (bus.kwr_addr < 5'd22) ks[bus.kwr_addr] = bus.kwr_data;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d at cycle %0d, want none",
                         bus.kwr_addr, cyc);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", bus.kwr_addr, e.addr);
                chk("wr_data", bus.kwr_data, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic word_t rotl(input word_t x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic word_t rotr(input word_t x, input logic [4:0] n);
        return rotl(x, 5'(32 - n));
    endfunction

    task automatic model_expand(input logic [127:0] key);
        word_t l[4];
        word_t a, b;
        int i, j;
        for (int k = 0; k < 4; k++) l[k] = key[32*k +: 32];
        ms[0] = 32'hB7E15163;
        for (int k = 1; k < 44; k++) ms[k] = ms[k-1] + 32'h9E3779B9;
        a = 0; b = 0; i = 0; j = 0;
        for (int n = 0; n < 132; n++) begin
            a = rotl(ms[i] + a + b, 5'd3);
            ms[i] = a;
            b = rotl(l[j] + a + b, 5'(a + b));
            l[j] = b;
            i = (i + 1) % 44;
            j = (j + 1) % 4;
        end
    endtask

    function automatic logic [127:0] rc6_cipher(input bit zset,
                                                input logic [127:0] din);
        word_t A, B, C, D, t, u, x;
        A = din[31:0]; B = din[63:32]; C = din[95:64]; D = din[127:96];
        if (zset) begin
            B = B + sk[0];
            D = D + sk[1];
            for (int r = 1; r <= 20; r++) begin
                t = rotl(B * (2 * B + 32'd1), 5'd5);
                u = rotl(D * (2 * D + 32'd1), 5'd5);
                A = rotl(A ^ t, u[4:0]) + sk[2*r];
                C = rotl(C ^ u, t[4:0]) + sk[2*r+1];
                x = A; A = B; B = C; C = D; D = x;
            end
            A = A + sk[42];
            C = C + sk[43];
        end else begin
            C = C - sk[43];
            A = A - sk[42];
            for (int r = 20; r >= 1; r--) begin
                x = D; D = C; C = B; B = A; A = x;
                u = rotl(D * (2 * D + 32'd1), 5'd5);
                t = rotl(B * (2 * B + 32'd1), 5'd5);
                C = rotr(C - sk[2*r+1], t[4:0]) ^ u;
                A = rotr(A - sk[2*r], u[4:0]) ^ t;
            end
            D = D - sk[1];
            B = B - sk[0];
        end
        return {D, C, B, A};
    endfunction

    task automatic push_run(input int acc);
        for (int m = 0; m < 22; m++) begin
            sb.push_back('{addr: 5'(m), data: {ms[2*m], ms[2*m+1]},
                           cyc: acc + 177 + m});
        end
    endtask

    task automatic launch(input logic [127:0] key, input bit hold);
        @(negedge clk);
        bus.key_in = key;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) bus.start = 1'b0;
        model_expand(key);
        push_run(acc_cyc);
        @(negedge clk);
        chk("busy_after_accept", bus.busy, 1'b1);
    endtask

    task automatic wait_until(input int rel);
        do @(negedge clk); while (cyc < acc_cyc + rel);
    endtask

    task automatic wait_done(input int exp);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", seen, 1'b1);
        if (seen) begin
            chk("done_cycle", cyc, exp);
            chk("busy_at_done", bus.busy, 1'b0);
            chk("kwr_en_at_done", bus.kwr_en, 1'b0);
        end
    endtask

    task automatic watch_quiet(input string name, input int n);
        int d;
        int w0;
        d = 0;
        w0 = wr_cnt;
        repeat (n) begin
            @(negedge clk);
            if (bus.done === 1'b1) d++;
        end
        chk({name, "_done"}, d, 0);
        chk({name, "_writes"}, wr_cnt - w0, 0);
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_busy"}, bus.busy, 1'b0);
        chk({name, "_done"}, bus.done, 1'b0);
        chk({name, "_kwr_en"}, bus.kwr_en, 1'b0);
        chk({name, "_kwr_addr"}, bus.kwr_addr, 5'd0);
        chk({name, "_kwr_data"}, bus.kwr_data, 64'd0);
    endtask

    task automatic load_sk();
        for (int i = 0; i < 22; i++) begin
            sk[2*i]   = ks[i][63:32];
            sk[2*i+1] = ks[i][31:0];
        end
    endtask

    initial begin
        logic [127:0] got;
        int w0;

        vecs[0] = '{key: 128'h0, pt: 128'h0,
                    ct: 128'h1ea44898_4edf29c1_78f7b156_36a5c38f};
        vecs[1] = '{key: 128'h78675645_34231201_efcdab89_67452301,
                    pt:  128'hf1e0dfce_bdac9b8a_79685746_35241302,
                    ct:  128'h183fa47e_36f6511f_23c61547_2f194e52};

        bus.start  = 1'b1;
        bus.key_in = '0;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check_cleared("reset");
        watch_quiet("idle", 300);

        // Table-driven known-answer runs through the key-store model.
        for (int v = 0; v < 2; v++) begin
            w0 = wr_cnt;
            launch(vecs[v].key, 1'b0);
            wait_done(acc_cyc + 199);
            chk("write_count", wr_cnt - w0, 22);
            chk("sb_empty", sb.size(), 0);
            load_sk();
            got = rc6_cipher(1'b1, vecs[v].pt);
            chk("encrypt_ct", got, vecs[v].ct);
            got = rc6_cipher(1'b0, vecs[v].ct);
            chk("decrypt_pt", got, vecs[v].pt);
        end

        // Abort in MIX.
        launch(128'h0, 1'b0);
        wait_until(99);
        reset = 1'b0;
        @(negedge clk);
        check_cleared("abort_mix");
        sb.delete();
        reset = 1'b1;
        watch_quiet("after_mix_abort", 250);

        // Abort mid-OUT: eight words land before the reset edge.
        w0 = wr_cnt;
        launch(128'h0, 1'b0);
        wait_until(184);
        reset = 1'b0;
        @(negedge clk);
        check_cleared("abort_out");
        chk("abort_out_writes", wr_cnt - w0, 8);
        sb.delete();
        reset = 1'b1;
        watch_quiet("after_out_abort", 250);

        // Fresh run after the aborts.
        launch(128'h0, 1'b0);
        wait_done(acc_cyc + 199);
        chk("fresh_sb_empty", sb.size(), 0);

        // Key change and stray starts while busy are ignored.
        launch(128'h0, 1'b0);
        wait_until(1);
        bus.key_in = '1;
        wait_until(49);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(189);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(acc_cyc + 199);
        chk("ignore_sb_empty", sb.size(), 0);
        watch_quiet("after_ignore", 20);

        // start held high: back-to-back runs, second accepted at cycle 200.
        launch(128'h0, 1'b1);
        push_run(acc_cyc + 200);
        wait_done(acc_cyc + 199);
        wait_until(200);
        chk("b2b_busy", bus.busy, 1'b1);
        bus.start = 1'b0;
        wait_done(acc_cyc + 399);
        chk("b2b_sb_empty", sb.size(), 0);
        watch_quiet("after_b2b", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
